fsm_wr: RTL and testbench

//  Write-side stage upstream of the 8-entry sample RAM and its reader/averager FSM.

---
 rtl/fsm_wr_pkg.sv | 11 +
 rtl/fsm_wr_sat_cnt.sv | 20 ++
 rtl/fsm_wr.sv | 106 ++++++++++
 tb/tb_fsm_wr.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_wr_pkg.sv
// Shared types and default sizing for the sample-RAM write stage.
package fsm_wr_pkg;

  localparam int DATA_W     = 16;
  localparam int DEPTH      = 8;
  localparam int ADDR_W     = 3;
  localparam int RD_HOLDOFF = 34;

  typedef enum logic [1:0] {FILL, HANDOFF, HOLD} wr_state_t;

endpackage

// File: rtl/fsm_wr_sat_cnt.sv
// Saturating up-counter with asynchronous active-low reset; sticks at all-ones.
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == {W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt <= '0;
    else if (inc) cnt <= sat_inc(cnt);
  end

endmodule

// File: rtl/fsm_wr.sv
// Write side of the sample RAM: fills DEPTH words, pulses read_en, then holds off.
// Optional drop counter enabled by defining FSM_WR_DROP_CNT_EN.
module fsm_wr
  import fsm_wr_pkg::*;
#(
  parameter int  DATA_W     = fsm_wr_pkg::DATA_W,
  parameter int  DEPTH      = fsm_wr_pkg::DEPTH,
  parameter int  RD_HOLDOFF = fsm_wr_pkg::RD_HOLDOFF,
  parameter int  DROP_W     = 8,
  localparam int ADDR_W     = $clog2(DEPTH),
  localparam int HOLD_W     = $clog2(RD_HOLDOFF + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sample_vld,
  input  logic [DATA_W-1:0] sample_i,
  output logic              wr_en,
  output logic [ADDR_W-1:0] addr_wr,
  output logic [DATA_W-1:0] wr_data,
  output logic              read_en,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  wr_state_t           state_p1, state_nxt;
  logic [ADDR_W-1:0]   wr_ptr_p1, wr_ptr_nxt;
  logic [HOLD_W-1:0]   hold_cnt_p1, hold_cnt_nxt;
  logic                vld_p1, vld_nxt;
  logic [ADDR_W-1:0]   addr_p1, addr_nxt;
  logic [DATA_W-1:0]   data_p1, data_nxt;
  logic                read_en_p1, read_en_nxt;

  always_comb begin
    state_nxt    = state_p1;
    wr_ptr_nxt   = wr_ptr_p1;
    hold_cnt_nxt = hold_cnt_p1;
    vld_nxt      = 1'b0;
    addr_nxt     = addr_p1;
    data_nxt     = data_p1;
    read_en_nxt  = 1'b0;
    case (state_p1)
      FILL: begin
        if (sample_vld) begin
          vld_nxt    = 1'b1;
          addr_nxt   = wr_ptr_p1;
          data_nxt   = sample_i;
          wr_ptr_nxt = wr_ptr_p1 + 1'b1;
          if (wr_ptr_p1 == ADDR_W'(DEPTH - 1)) begin
            wr_ptr_nxt = '0;
            state_nxt  = HANDOFF;
          end
        end
      end
      HANDOFF: begin
        read_en_nxt  = 1'b1;
        hold_cnt_nxt = HOLD_W'(RD_HOLDOFF - 1);
        state_nxt    = HOLD;
      end
      HOLD: begin
        // Reader needs the RAM frozen until it is back in IDLE.
        if (hold_cnt_p1 == '0) state_nxt = FILL;
        else hold_cnt_nxt = hold_cnt_p1 - 1'b1;
      end
      default: state_nxt = FILL;
    endcase
  end

  // ---- stage p1: registered state and RAM write port ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_p1    <= FILL;
      wr_ptr_p1   <= '0;
      hold_cnt_p1 <= '0;
      vld_p1      <= 1'b0;
      addr_p1     <= '0;
      data_p1     <= '0;
      read_en_p1  <= 1'b0;
    end else begin
      state_p1    <= state_nxt;
      wr_ptr_p1   <= wr_ptr_nxt;
      hold_cnt_p1 <= hold_cnt_nxt;
      vld_p1      <= vld_nxt;
      addr_p1     <= addr_nxt;
      data_p1     <= data_nxt;
      read_en_p1  <= read_en_nxt;
    end
  end

  assign wr_en   = vld_p1;
  assign addr_wr = addr_p1;
  assign wr_data = data_p1;
  assign read_en = read_en_p1;
  assign busy    = (state_p1 != FILL);

`ifdef FSM_WR_DROP_CNT_EN
  sat_cnt #(.W(DROP_W)) u_drop_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (sample_vld && busy),
    .cnt  (drop_cnt)
  );
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_fsm_wr.sv
// Self-checking bench for fsm_wr: vector table, directed corner sequences, random traffic.
module tb_fsm_wr;

  localparam int DEPTH    = 8;
  localparam int BUSY_LEN = 35;
  localparam int DROP_MAX = 255;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sample_vld = 1'b0;
  logic [15:0] sample_i = '0;
  logic        wr_en;
  logic [2:0]  addr_wr;
  logic [15:0] wr_data;
  logic        read_en;
  logic        busy;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int failures = 0;
  int rd_seen = 0;

  fsm_wr dut (
    .clk        (clk),
    .rstn       (rstn),
    .sample_vld (sample_vld),
    .sample_i   (sample_i),
    .wr_en      (wr_en),
    .addr_wr    (addr_wr),
    .wr_data    (wr_data),
    .read_en    (read_en),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural reference: samples fill a block; a full block opens a fixed busy window.
  int          m_count, m_busy_left, m_drops;
  logic        m_wr_en, m_rd;
  logic [2:0]  m_addr;
  logic [15:0] m_data;

  function automatic logic [7:0] exp_drop();
`ifdef FSM_WR_DROP_CNT_EN
    return (m_drops > DROP_MAX) ? 8'(DROP_MAX) : 8'(m_drops);
`else
    return 8'd0;
`endif
  endfunction

  task automatic model_reset();
    m_count = 0; m_busy_left = 0; m_drops = 0;
    m_wr_en = 1'b0; m_rd = 1'b0; m_addr = '0; m_data = '0;
  endtask

  task automatic model_edge(input logic v, input logic [15:0] d);
    logic rd_next;
    rd_next = (m_busy_left == BUSY_LEN);
    if (m_busy_left > 0) begin
      if (v) m_drops++;
      m_busy_left--;
      m_wr_en = 1'b0;
    end else if (v) begin
      m_wr_en = 1'b1;
      m_addr  = 3'(m_count);
      m_data  = d;
      m_count++;
      if (m_count == DEPTH) begin
        m_count = 0;
        m_busy_left = BUSY_LEN;
      end
    end else begin
      m_wr_en = 1'b0;
    end
    m_rd = rd_next;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge: drive, let one rising edge pass, compare at the next falling edge.
  task automatic step(input logic v, input logic [15:0] d);
    sample_vld = v;
    sample_i   = d;
    @(posedge clk);
    model_edge(v, d);
    @(negedge clk);
    if (read_en === 1'b1) rd_seen++;
    check("model", {34'd0, wr_en, addr_wr, wr_data, read_en, busy, drop_cnt},
          {34'd0, m_wr_en, m_addr, m_data, m_rd, (m_busy_left > 0), exp_drop()});
  endtask

  task automatic do_reset();
    sample_vld = 1'b0;
    #2 rstn = 1'b0;
    #1 check("reset_outputs", {34'd0, wr_en, addr_wr, wr_data, read_en, busy, drop_cnt}, 64'd0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (busy && k < 200) begin
      step(1'b0, 16'h0);
      k++;
    end
    check("drain_bound", {63'd0, busy}, 64'd0);
  endtask

  typedef struct {
    logic        vld;
    logic [15:0] d;
    logic        wr_en;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        rd;
    logic        busy;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int n_busy, gap;
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 16'(i + 1), 1'b1, 3'(i), 16'(i + 1), 1'b0, (i == 7)};
    vecs[8]  = '{1'b0, 16'h0000, 1'b0, 3'd7, 16'h0008, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 16'h0000, 1'b0, 3'd7, 16'h0008, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 16'h0055, 1'b0, 3'd7, 16'h0008, 1'b0, 1'b1};

    model_reset();
    @(negedge clk);
    check("reset_outputs_init", {34'd0, wr_en, addr_wr, wr_data, read_en, busy, drop_cnt}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Back-to-back block 1..8 from the table, then measure the busy window.
    n_busy = 0;
    for (int i = 0; i < 11; i++) begin
      step(vecs[i].vld, vecs[i].d);
      check($sformatf("vec%0d", i), {35'd0, wr_en, addr_wr, wr_data, read_en, busy},
            {35'd0, vecs[i].wr_en, vecs[i].addr, vecs[i].data, vecs[i].rd, vecs[i].busy});
      if (busy) n_busy++;
    end
    for (int k = 0; k < 100 && busy; k++) begin
      step(1'b0, 16'h0);
      if (busy) n_busy++;
    end
    check("busy_window", 64'(n_busy), 64'(BUSY_LEN));
    check("busy_cleared", {63'd0, busy}, 64'd0);

    // Random gaps between strobes: read_en only after the 8th write.
    rd_seen = 0;
    for (int s = 0; s < 8; s++) begin
      gap = int'($urandom_range(1, 5));
      for (int g = 0; g < gap; g++) step(1'b0, 16'h0);
      step(1'b1, 16'($urandom));
      check("gap_wr", {60'd0, wr_en, addr_wr}, {60'd0, 1'b1, 3'(s)});
      if (s < 7) check("gap_no_rd_early", 64'(rd_seen), 64'd0);
    end
    drain();
    check("gap_rd_once", 64'(rd_seen), 64'd1);

    // Strobes during the busy window are dropped; next block restarts at addr 0.
    do_reset();
    for (int s = 0; s < 8; s++) step(1'b1, 16'(16'h0100 + s));
    for (int s = 0; s < 5; s++) begin
      step(1'b1, 16'hDEAD);
      check("hold_no_wr", {63'd0, wr_en}, 64'd0);
    end
`ifdef FSM_WR_DROP_CNT_EN
    check("drop5", 64'(drop_cnt), 64'd5);
`else
    check("drop5", 64'(drop_cnt), 64'd0);
`endif
    drain();
    step(1'b1, 16'hABCD);
    check("after_hold_addr0", {44'd0, wr_en, addr_wr, wr_data}, {44'd0, 1'b1, 3'd0, 16'hABCD});

    // Async reset mid-block, then a clean block with exactly one read_en.
    do_reset();
    for (int s = 0; s < 5; s++) step(1'b1, 16'(16'd100 * (s + 1)));
    do_reset();
    rd_seen = 0;
    for (int s = 0; s < 8; s++) begin
      step(1'b1, 16'hFFFF);
      check("post_reset_addr", {61'd0, addr_wr}, 64'(s));
    end
    drain();
    check("post_reset_rd_once", 64'(rd_seen), 64'd1);

    // Continuous strobing drives the drop counter into saturation.
    do_reset();
    for (int c = 0; c < 430; c++) step(1'b1, 16'(c));
`ifdef FSM_WR_DROP_CNT_EN
    check("drop_saturate", 64'(drop_cnt), 64'(DROP_MAX));
`else
    check("drop_off_zero", 64'(drop_cnt), 64'd0);
`endif

    // Random traffic against the reference model.
    do_reset();
    for (int c = 0; c < 1500; c++) step(($urandom % 3) == 0, 16'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
